// File: rtl/cpc_ram_paging_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpc_ram_paging_ctrl_if
//   Bus bundle between the Z80/CPC expansion edge and the RAM paging
//   controller: the Z80 control/address/data lines on one side, and the
//   SRAM high address, strobes and RAMDIS on the other.
//
//   Z80 side  : A[15:0], D[7:0], IOREQ_B, MREQ_B, WR_B, RD_B, RFSH_B
//   SRAM side : ramadr_hi[ADR_HI_W-1:0], ramcs_b, ramwe_b, ramoe_b, RAMDIS
//
//   master : the CPU/bus side (drives the Z80 lines, observes SRAM lines)
//   slave  : the paging controller (observes Z80 lines, drives SRAM lines)
// ---------------------------------------------------------------------------
interface cpc_ram_paging_ctrl_if #(
    parameter  int EXT_BANK_BITS = 0,
    localparam int ADR_HI_W      = 5 + EXT_BANK_BITS
);
    logic [15:0]         A;
    logic [7:0]          D;
    logic                IOREQ_B;
    logic                MREQ_B;
    logic                WR_B;
    logic                RD_B;
    logic                RFSH_B;
    logic [ADR_HI_W-1:0] ramadr_hi;
    logic                ramcs_b;
    logic                ramwe_b;
    logic                ramoe_b;
    logic                RAMDIS;

    modport master (
        output A, D, IOREQ_B, MREQ_B, WR_B, RD_B, RFSH_B,
        input  ramadr_hi, ramcs_b, ramwe_b, ramoe_b, RAMDIS
    );

    modport slave (
        input  A, D, IOREQ_B, MREQ_B, WR_B, RD_B, RFSH_B,
        output ramadr_hi, ramcs_b, ramwe_b, ramoe_b, RAMDIS
    );
endinterface

// File: rtl/cpc_ram_paging_ctrl.sv
// ---------------------------------------------------------------------------
// cpc_ram_paging_ctrl
//   RAM expansion paging controller for the Amstrad CPC. Snoops Z80 OUT
//   cycles to port &7Fxx with D[7:6]=11, filters the strobe for a minimum
//   width, and commits {map mode, bank} when the strobe goes away. The map
//   mode and the live address select the SRAM block; refresh cycles never
//   reach the SRAM.
//
//   Parameters
//     EXT_BANK_BITS : extra bank bits taken from ~A[8 +: n], 0..3 (0 = 512K)
//     MIN_STROBE    : samples of a valid IO write before commit is armed, 1..7
//
//   Ports
//     CLK     : CPU clock, all state changes on the rising edge
//     RESET_B : asynchronous active-low reset
//     bus     : Z80 bus in, SRAM control out (slave modport)
//     mode_q  : registered map mode (debug)
//     bank_q  : registered bank (debug)
// ---------------------------------------------------------------------------
module cpc_ram_paging_ctrl #(
    parameter  int EXT_BANK_BITS = 0,
    parameter  int MIN_STROBE    = 1,
    localparam int BANK_W        = 3 + EXT_BANK_BITS,
    localparam int ADR_HI_W      = BANK_W + 2
) (
    input  logic                        CLK,
    input  logic                        RESET_B,
    cpc_ram_paging_ctrl_if.slave        bus,
    output logic [2:0]                  mode_q,
    output logic [BANK_W-1:0]           bank_q
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_ARM   = 2'd2
    } state_t;

    // Sampled Z80 lines
    logic       ioreq_s;
    logic       wr_s;
    logic       a15_s;
    logic [2:0] a_hi_s;
    logic [7:0] d_s;
    logic       sample_valid;

    // Paging state
    state_t            state;
    logic [2:0]        cnt;
    logic [2:0]        cap_mode;
    logic [BANK_W-1:0] cap_bank;
    logic [BANK_W-1:0] bank_in;
    logic              seen_idle;
    logic              iowr_s;

    // Address map
    logic                sel;
    logic [1:0]          blk;
    logic [ADR_HI_W-1:0] adr_hold;

    // Bus lines this block never looks at.
    logic unused_bus;
    assign unused_bus = ^{bus.A[13:11], bus.A[7:0]};

    // -----------------------------------------------------------------------
    // Input sampling. The reset values read as an idle bus.
    // -----------------------------------------------------------------------
    // NOTE: registers use non-blocking assignments so every flop sees the
    // pre-edge value of every other flop, whatever the statement order.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            ioreq_s      <= 1'b1;
            wr_s         <= 1'b1;
            a15_s        <= 1'b1;
            a_hi_s       <= 3'd0;
            d_s          <= 8'd0;
            sample_valid <= 1'b0;
        end else begin
            ioreq_s      <= bus.IOREQ_B;
            wr_s         <= bus.WR_B;
            a15_s        <= bus.A[15];
            a_hi_s       <= bus.A[10:8];
            d_s          <= bus.D;
            sample_valid <= 1'b1;
        end
    end

    assign iowr_s = !ioreq_s && !wr_s && !a15_s && (d_s[7:6] == 2'b11);

    // Extended bank bits are the inverted upper address byte, placed as MSBs.
    generate
        if (EXT_BANK_BITS == 0) begin : g_no_ext
            logic unused_a_hi;
            assign unused_a_hi = ^a_hi_s;
            assign bank_in     = d_s[5:3];
        end else begin : g_ext
            assign bank_in = {~a_hi_s[EXT_BANK_BITS-1:0], d_s[5:3]};
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Strobe filter / commit FSM.
    // seen_idle blocks a strobe that was already active across reset release:
    // only a real inactive sample re-enables detection.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            cap_mode  <= 3'd0;
            cap_bank  <= '0;
            mode_q    <= 3'd0;
            bank_q    <= '0;
            seen_idle <= 1'b0;
        end else begin
            if (sample_valid && !iowr_s) begin
                seen_idle <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (iowr_s && seen_idle) begin
                        cnt      <= 3'd1;
                        cap_mode <= d_s[2:0];
                        cap_bank <= bank_in;
                        state    <= (MIN_STROBE == 1) ? S_ARM : S_COUNT;
                    end
                end

                S_COUNT: begin
                    if (iowr_s) begin
                        cnt      <= cnt + 3'd1;
                        cap_mode <= d_s[2:0];
                        cap_bank <= bank_in;
                        if (cnt + 3'd1 == 3'(MIN_STROBE)) begin
                            state <= S_ARM;
                        end
                    end else begin
                        // Too short: treated as a glitch, nothing committed.
                        cnt   <= 3'd0;
                        state <= S_IDLE;
                    end
                end

                S_ARM: begin
                    if (iowr_s) begin
                        // Keep recapturing so the last sampled data wins.
                        cap_mode <= d_s[2:0];
                        cap_bank <= bank_in;
                    end else begin
                        mode_q <= cap_mode;
                        bank_q <= cap_bank;
                        cnt    <= 3'd0;
                        state  <= S_IDLE;
                    end
                end

                default: begin
                    cnt   <= 3'd0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Address map from the committed mode and the live A[15:14].
    // -----------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel = 1'b0;
        blk = 2'd0;
        case (mode_q)
            3'd0: begin
                sel = 1'b0;
            end
            3'd1, 3'd3: begin
                sel = (bus.A[15:14] == 2'b11);
                blk = 2'd3;
            end
            3'd2: begin
                sel = 1'b1;
                blk = bus.A[15:14];
            end
            default: begin
                sel = (bus.A[15:14] == 2'b01);
                blk = mode_q[1:0];
            end
        endcase
    end

    // Last selected address, so the SRAM high address does not wander while
    // the expansion is deselected.
    // NOTE: only this small hold register needs a reset; it defines the
    // ramadr_hi value seen straight out of reset.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            adr_hold <= '0;
        end else if (sel) begin
            adr_hold <= {bank_q, blk};
        end
    end

    // Refresh cycles carry MREQ but must never select the SRAM.
    assign bus.ramcs_b   = !(sel && !bus.MREQ_B && bus.RFSH_B);
    assign bus.ramwe_b   = bus.ramcs_b || bus.WR_B;
    assign bus.ramoe_b   = bus.ramcs_b || bus.RD_B;
    assign bus.RAMDIS    = !bus.ramcs_b;
    assign bus.ramadr_hi = sel ? {bank_q, blk} : adr_hold;

endmodule

// File: tb/tb_cpc_ram_paging_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpc_ram_paging_ctrl
//   Three controllers share one Z80 bus:
//     dut0 : EXT_BANK_BITS=0, MIN_STROBE=1
//     dut2 : EXT_BANK_BITS=2, MIN_STROBE=1
//     dut3 : EXT_BANK_BITS=0, MIN_STROBE=3
//   A reference model keeps {mode, bank} per controller from the OUT cycles
//   issued, and a small SRAM array stands in for the expansion RAM of dut0.
// ---------------------------------------------------------------------------
module tb_cpc_ram_paging_ctrl;

    localparam int EXT_CFG [3] = '{0, 2, 0};
    localparam int MIN_CFG [3] = '{1, 1, 3};

    logic        clk;
    logic        rst_b;
    logic [15:0] a;
    logic [7:0]  d;
    logic        ioreq_b, mreq_b, wr_b, rd_b, rfsh_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state
    int m_mode [3];
    int m_bank [3];
    logic [7:0] sram [bit [20:0]];

    // Collected DUT outputs
    logic [6:0] adr_o  [3];
    logic       cs_o   [3];
    logic       we_o   [3];
    logic       oe_o   [3];
    logic       dis_o  [3];
    logic [2:0] mode_o [3];
    logic [4:0] bank_o [3];

    logic [2:0] bank0;
    logic [4:0] bank2;
    logic [2:0] bank3;

    cpc_ram_paging_ctrl_if #(.EXT_BANK_BITS(0)) bus0 ();
    cpc_ram_paging_ctrl_if #(.EXT_BANK_BITS(2)) bus2 ();
    cpc_ram_paging_ctrl_if #(.EXT_BANK_BITS(0)) bus3 ();

    assign bus0.A = a;  assign bus0.D = d;  assign bus0.IOREQ_B = ioreq_b;
    assign bus0.MREQ_B = mreq_b;  assign bus0.WR_B = wr_b;
    assign bus0.RD_B = rd_b;  assign bus0.RFSH_B = rfsh_b;
    assign bus2.A = a;  assign bus2.D = d;  assign bus2.IOREQ_B = ioreq_b;
    assign bus2.MREQ_B = mreq_b;  assign bus2.WR_B = wr_b;
    assign bus2.RD_B = rd_b;  assign bus2.RFSH_B = rfsh_b;
    assign bus3.A = a;  assign bus3.D = d;  assign bus3.IOREQ_B = ioreq_b;
    assign bus3.MREQ_B = mreq_b;  assign bus3.WR_B = wr_b;
    assign bus3.RD_B = rd_b;  assign bus3.RFSH_B = rfsh_b;

    cpc_ram_paging_ctrl #(.EXT_BANK_BITS(0), .MIN_STROBE(1)) dut0 (
        .CLK(clk), .RESET_B(rst_b), .bus(bus0), .mode_q(mode_o[0]), .bank_q(bank0));
    cpc_ram_paging_ctrl #(.EXT_BANK_BITS(2), .MIN_STROBE(1)) dut2 (
        .CLK(clk), .RESET_B(rst_b), .bus(bus2), .mode_q(mode_o[1]), .bank_q(bank2));
    cpc_ram_paging_ctrl #(.EXT_BANK_BITS(0), .MIN_STROBE(3)) dut3 (
        .CLK(clk), .RESET_B(rst_b), .bus(bus3), .mode_q(mode_o[2]), .bank_q(bank3));

    assign bank_o[0] = {2'b00, bank0};
    assign bank_o[1] = bank2;
    assign bank_o[2] = {2'b00, bank3};
    assign adr_o[0]  = {2'b00, bus0.ramadr_hi};
    assign adr_o[1]  = bus2.ramadr_hi;
    assign adr_o[2]  = {2'b00, bus3.ramadr_hi};
    assign cs_o[0]  = bus0.ramcs_b;  assign cs_o[1]  = bus2.ramcs_b;  assign cs_o[2]  = bus3.ramcs_b;
    assign we_o[0]  = bus0.ramwe_b;  assign we_o[1]  = bus2.ramwe_b;  assign we_o[2]  = bus3.ramwe_b;
    assign oe_o[0]  = bus0.ramoe_b;  assign oe_o[1]  = bus2.ramoe_b;  assign oe_o[2]  = bus3.ramoe_b;
    assign dis_o[0] = bus0.RAMDIS;   assign dis_o[1] = bus2.RAMDIS;   assign dis_o[2] = bus3.RAMDIS;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Model
    // ---------------------------------------------------------------------
    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0;
            m_bank[i] = 0;
        end
    endfunction

    // An OUT cycle is taken when it is an IO write to A15=0 with D[7:6]=11
    // and the strobe was sampled at least MIN_STROBE times.
    function automatic void model_io(input logic [15:0] addr, input logic [7:0] data,
                                     input int n, input bit io_write);
        int ai;
        int di;
        ai = int'(addr);
        di = int'(data);
        for (int i = 0; i < 3; i++) begin
            if (io_write && ai < 32768 && (di / 64) == 3 && n >= MIN_CFG[i]) begin
                m_mode[i] = di % 8;
                m_bank[i] = ((di / 8) % 8) + (((~ai >> 8) & ((1 << EXT_CFG[i]) - 1)) * 8);
            end
        end
    endfunction

    function automatic void exp_map(input int mode, input int bank, input logic [15:0] addr,
                                    output bit sel, output int adr);
        int q;
        int blk;
        q   = int'(addr) / 16384;
        sel = 1'b0;
        blk = 0;
        if (mode == 1 || mode == 3) begin
            sel = (q == 3);
            blk = 3;
        end else if (mode == 2) begin
            sel = 1'b1;
            blk = q;
        end else if (mode >= 4) begin
            sel = (q == 1);
            blk = mode - 4;
        end
        adr = bank * 4 + blk;
    endfunction

    // ---------------------------------------------------------------------
    // Bus drivers
    // ---------------------------------------------------------------------
    task automatic bus_release();
        ioreq_b = 1'b1;
        mreq_b  = 1'b1;
        wr_b    = 1'b1;
        rd_b    = 1'b1;
        rfsh_b  = 1'b1;
    endtask

    // kind: 0 IO write, 1 IO read, 2 MREQ-only write, 3 IO write with MREQ also low
    task automatic io_cycle(input logic [15:0] addr, input logic [7:0] data,
                            input int n, input int kind);
        @(negedge clk);
        a = addr;
        d = data;
        case (kind)
            0: begin ioreq_b = 1'b0; wr_b = 1'b0; end
            1: begin ioreq_b = 1'b0; rd_b = 1'b0; end
            2: begin mreq_b  = 1'b0; wr_b = 1'b0; end
            default: begin ioreq_b = 1'b0; mreq_b = 1'b0; wr_b = 1'b0; end
        endcase
        repeat (n) @(posedge clk);
        @(negedge clk);
        bus_release();
        repeat (3) @(negedge clk);
        model_io(addr, data, n, (kind == 0) || (kind == 3));
    endtask

    // One memory cycle, checked against the model for every controller.
    task automatic mem_access(input string name, input logic [15:0] addr, input bit is_wr,
                              input bit rfsh_low, input logic [7:0] wdata,
                              output logic [7:0] rdata, output bit hit);
        bit         sel;
        int         adr;
        logic       ecs;
        bit [20:0]  key;
        rdata = 8'h00;
        hit   = 1'b0;
        @(negedge clk);
        a      = addr;
        mreq_b = 1'b0;
        rfsh_b = !rfsh_low;
        if (is_wr) begin
            wr_b = 1'b0;
            d    = wdata;
        end else begin
            rd_b = 1'b0;
        end
        #2;
        for (int i = 0; i < 3; i++) begin
            exp_map(m_mode[i], m_bank[i], addr, sel, adr);
            ecs = !(sel && !rfsh_low);
            total_cnt++;
            if (cs_o[i] !== ecs)
                $display("FAIL %s dut%0d ramcs_b got %b want %b", name, i, cs_o[i], ecs);
            else pass_cnt++;
            total_cnt++;
            if (we_o[i] !== (ecs | !is_wr))
                $display("FAIL %s dut%0d ramwe_b got %b want %b", name, i, we_o[i], ecs | !is_wr);
            else pass_cnt++;
            total_cnt++;
            if (oe_o[i] !== (ecs | is_wr))
                $display("FAIL %s dut%0d ramoe_b got %b want %b", name, i, oe_o[i], ecs | is_wr);
            else pass_cnt++;
            total_cnt++;
            if (dis_o[i] !== !ecs)
                $display("FAIL %s dut%0d RAMDIS got %b want %b", name, i, dis_o[i], !ecs);
            else pass_cnt++;
            if (sel) begin
                total_cnt++;
                if (adr_o[i] !== 7'(adr))
                    $display("FAIL %s dut%0d ramadr_hi got %0d want %0d", name, i, adr_o[i], adr);
                else pass_cnt++;
            end
        end
        key = {adr_o[0], addr[13:0]};
        if (!cs_o[0] && is_wr && !we_o[0]) sram[key] = wdata;
        if (!cs_o[0] && !is_wr && !oe_o[0] && sram.exists(key)) begin
            rdata = sram[key];
            hit   = 1'b1;
        end
        #1;
        bus_release();
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        logic [7:0] rd;
        bit         hit;
        bus_release();
        a     = 16'h0000;
        d     = 8'h00;
        rst_b = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({mode_o[i], bank_o[i]} !== 8'h00)
                $display("FAIL reset dut%0d mode/bank got %0d/%0d want 0/0", i, mode_o[i], bank_o[i]);
            else pass_cnt++;
            total_cnt++;
            if ({cs_o[i], we_o[i], oe_o[i], dis_o[i]} !== 4'b1110)
                $display("FAIL reset dut%0d cs/we/oe/dis got %b%b%b%b want 1110",
                         i, cs_o[i], we_o[i], oe_o[i], dis_o[i]);
            else pass_cnt++;
            total_cnt++;
            if (adr_o[i] !== 7'd0)
                $display("FAIL reset dut%0d ramadr_hi got %0d want 0", i, adr_o[i]);
            else pass_cnt++;
        end
        @(negedge clk);
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        io_cycle(16'h7FFF, 8'hC0, 3, 0);
        mem_access("mode0_read_4000", 16'h4000, 1'b0, 1'b0, 8'h00, rd, hit);
    endtask

    task automatic test_markers();
        logic [7:0] rd;
        bit         hit;
        for (int bank = 0; bank < 8; bank++) begin
            for (int block = 0; block < 4; block++) begin
                io_cycle(16'h7FFF, 8'(32'hC4 | (bank << 3) | block), 3, 0);
                mem_access("marker_poke", 16'h4000, 1'b1, 1'b0, 8'(bank * 4 + block), rd, hit);
            end
        end
        for (int bank = 0; bank < 8; bank++) begin
            for (int block = 0; block < 4; block++) begin
                io_cycle(16'h7FFF, 8'(32'hC4 | (bank << 3) | block), 3, 0);
                mem_access("marker_peek", 16'h4000, 1'b0, 1'b0, 8'h00, rd, hit);
                total_cnt++;
                if (!hit || rd !== 8'(bank * 4 + block))
                    $display("FAIL marker bank%0d blk%0d got %0d (hit %b) want %0d",
                             bank, block, rd, hit, bank * 4 + block);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_mode_maps();
        logic [7:0] rd;
        bit         hit;
        io_cycle(16'h7FFF, 8'hEA, 3, 0);
        for (int q = 0; q < 4; q++)
            mem_access("mode2_bank5", 16'(q * 16384), 1'b0, 1'b0, 8'h00, rd, hit);
        io_cycle(16'h7FFF, 8'hC1, 3, 0);
        for (int q = 0; q < 4; q++)
            mem_access("mode1", 16'(q * 16384 + 16'h0123), 1'b0, 1'b0, 8'h00, rd, hit);
        io_cycle(16'h7FFF, 8'hC3, 3, 0);
        mem_access("mode3_c000", 16'hC000, 1'b1, 1'b0, 8'h55, rd, hit);
    endtask

    task automatic test_ext_bank();
        logic [7:0] rd;
        bit         hit;
        io_cycle(16'h7CFF, 8'hFC, 3, 0);
        total_cnt++;
        if (bank_o[1] !== 5'b11111)
            $display("FAIL ext_bank dut2 bank_q got %0d want 31", bank_o[1]);
        else pass_cnt++;
        mem_access("ext_bank31", 16'h4000, 1'b0, 1'b0, 8'h00, rd, hit);
        io_cycle(16'h7FFF, 8'hC4, 3, 0);
        mem_access("ext_bank0", 16'h4000, 1'b0, 1'b0, 8'h00, rd, hit);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({mode_o[i], bank_o[i]} !== {3'(m_mode[i]), 5'(m_bank[i])})
                $display("FAIL ext_bank_state dut%0d got %0d/%0d want %0d/%0d",
                         i, mode_o[i], bank_o[i], m_mode[i], m_bank[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_min_strobe();
        // Two samples: only the MIN_STROBE=1 controllers take it.
        io_cycle(16'h7FFF, 8'hC5, 2, 0);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({mode_o[i], bank_o[i]} !== {3'(m_mode[i]), 5'(m_bank[i])})
                $display("FAIL short_strobe dut%0d got %0d/%0d want %0d/%0d",
                         i, mode_o[i], bank_o[i], m_mode[i], m_bank[i]);
            else pass_cnt++;
        end
        // Four samples on dut3: old value one edge after release, new value on the next.
        @(negedge clk);
        a = 16'h7FFF; d = 8'hCE; ioreq_b = 1'b0; wr_b = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus_release();
        @(negedge clk);
        total_cnt++;
        if (mode_o[2] !== 3'(m_mode[2]))
            $display("FAIL latency_early dut3 mode got %0d want %0d", mode_o[2], m_mode[2]);
        else pass_cnt++;
        @(negedge clk);
        model_io(16'h7FFF, 8'hCE, 4, 1'b1);
        total_cnt++;
        if ({mode_o[2], bank_o[2]} !== {3'd6, 5'd1})
            $display("FAIL latency_commit dut3 got %0d/%0d want 6/1", mode_o[2], bank_o[2]);
        else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ignored_and_refresh();
        logic [7:0] rd;
        bit         hit;
        io_cycle(16'h7FFF, 8'hC6, 3, 0);
        io_cycle(16'hFFFF, 8'hC5, 3, 0);  // A15 high
        io_cycle(16'h7FFF, 8'h85, 3, 0);  // D[7:6] != 11
        io_cycle(16'h7FFF, 8'hC5, 3, 2);  // memory write
        io_cycle(16'h7FFF, 8'hC5, 3, 1);  // IO read
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({mode_o[i], bank_o[i]} !== {3'(m_mode[i]), 5'(m_bank[i])})
                $display("FAIL ignored dut%0d got %0d/%0d want %0d/%0d",
                         i, mode_o[i], bank_o[i], m_mode[i], m_bank[i]);
            else pass_cnt++;
        end
        io_cycle(16'h7EFF, 8'hD4, 3, 3);  // IO write with MREQ also low still counts
        io_cycle(16'h7FFF, 8'hC4, 3, 0);
        mem_access("refresh_4000", 16'h4000, 1'b0, 1'b1, 8'h00, rd, hit);
        mem_access("no_refresh_4000", 16'h4000, 1'b0, 1'b0, 8'h00, rd, hit);
    endtask

    task automatic test_hold();
        // Mode 4, bank 3; A stays at &7FFF (block 1 window) across several edges.
        io_cycle(16'h7FFF, 8'hDC, 3, 0);
        @(negedge clk);
        a = 16'h8000;
        #1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (adr_o[i] !== 7'd12)
                $display("FAIL hold dut%0d ramadr_hi got %0d want 12", i, adr_o[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_out();
        io_cycle(16'h7FFF, 8'hC6, 3, 0);
        @(negedge clk);
        a = 16'h7FFF; d = 8'hCD; ioreq_b = 1'b0; wr_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (mode_o[i] !== 3'd0)
                $display("FAIL reset_mid dut%0d mode got %0d want 0", i, mode_o[i]);
            else pass_cnt++;
        end
        @(negedge clk);
        rst_b = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus_release();
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({mode_o[i], bank_o[i]} !== 8'h00)
                $display("FAIL no_commit_after_reset dut%0d got %0d/%0d want 0/0",
                         i, mode_o[i], bank_o[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [7:0]  rd;
        bit          hit;
        logic [15:0] addr;
        logic [7:0]  data;
        int          kind;
        for (int it = 0; it < 40; it++) begin
            addr = 16'($urandom);
            if ($urandom_range(0, 4) != 0) addr[15] = 1'b0;
            data = 8'($urandom);
            if ($urandom_range(0, 3) != 0) data[7:6] = 2'b11;
            kind = ($urandom_range(0, 5) < 4) ? 0 : int'($urandom_range(1, 3));
            io_cycle(addr, data, int'($urandom_range(1, 4)), kind);
            for (int i = 0; i < 3; i++) begin
                total_cnt++;
                if ({mode_o[i], bank_o[i]} !== {3'(m_mode[i]), 5'(m_bank[i])})
                    $display("FAIL random_state it%0d dut%0d got %0d/%0d want %0d/%0d",
                             it, i, mode_o[i], bank_o[i], m_mode[i], m_bank[i]);
                else pass_cnt++;
            end
            mem_access("random_mem", 16'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                       8'($urandom), rd, hit);
        end
    endtask

    initial begin
        rst_b = 1'b0;
        test_reset();
        test_markers();
        test_mode_maps();
        test_ext_bank();
        test_min_strobe();
        test_ignored_and_refresh();
        test_hold();
        test_reset_mid_out();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
